// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the flag/condition unit: condition codes, flag bit
// positions inside {Z,V,N}, and the branch-resolution state encoding.
package flag_cond_unit_pkg;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } br_state_t;

endpackage

// File: rtl/flag_cond_eval.sv
// Pure combinational branch condition evaluator: condition code x {Z,V,N} -> taken.
module flag_cond_eval
  import flag_cond_unit_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLG_Z];
  assign v = flags[FLG_V];
  assign n = flags[FLG_N];

  // NOTE: assign a default before the case so no path leaves 'taken' unassigned (no latch).
  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = !z;
      CC_EQ:   taken = z;
      CC_GT:   taken = !z && !n;
      CC_LT:   taken = n;
      CC_GE:   taken = z || (!z && !n);
      CC_LE:   taken = n || z;
      CC_OV:   taken = v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Flag register read side: holds committed Z/V/N, counts in-flight flag writers and
// resolves decode's branch conditions once all older writers commit (EX result forwarded).
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter  int MAX_PEND = 3,
  localparam int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_flag_wr,
  input  logic       flag_wen,
  input  logic [2:0] flag_d,
  input  logic       flush,
  input  logic       br_valid,
  input  logic [2:0] br_ccc,
  output logic       br_ready,
  output logic       br_done,
  output logic       br_taken,
  output logic [2:0] flags_q,
  output logic       pend_full,
  output logic       pend_err
);

  br_state_t     state, state_nxt;
  logic [CW-1:0] pending, pending_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic [CW-1:0] older;
  logic [2:0]    ccc_q, ccc_nxt;
  logic [2:0]    eval_ccc;
  logic [2:0]    flags_nxt;
  logic          taken_nxt;
  logic          eval_taken;
  logic          err_set;
  logic          accept;

  assign flags_nxt = flag_wen ? flag_d : flags_q;
  assign pend_full = (pending == CW'(MAX_PEND));
  assign br_ready  = (state == ST_IDLE);
  assign br_done   = (state == ST_RESP);
  assign accept    = br_ready && br_valid && !flush;

  // A commit in the acceptance cycle retires one older writer before the branch counts them.
  assign older = (flag_wen && (pending != '0)) ? pending - CW'(1) : pending;

  // In IDLE the incoming code is evaluated; while waiting, the latched one is.
  // flags_nxt already carries the forwarded commit value in both cases.
  assign eval_ccc = (state == ST_IDLE) ? br_ccc : ccc_q;

  flag_cond_eval u_eval (
    .ccc   (eval_ccc),
    .flags (flags_nxt),
    .taken (eval_taken)
  );

  always_comb begin
    pending_nxt = pending;
    err_set     = 1'b0;
    if (issue_flag_wr && !flag_wen) begin
      if (pend_full) err_set = 1'b1;
      else           pending_nxt = pending + CW'(1);
    end else if (flag_wen && !issue_flag_wr) begin
      if (pending == '0) err_set = 1'b1;
      else               pending_nxt = pending - CW'(1);
    end else if (flag_wen && issue_flag_wr && (pending == '0)) begin
      err_set = 1'b1;
    end
    if (flush) pending_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ccc_nxt   = ccc_q;
    taken_nxt = br_taken;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          ccc_nxt = br_ccc;
          if (older == '0) begin
            state_nxt = ST_RESP;
            taken_nxt = eval_taken;
          end else begin
            state_nxt = ST_WAIT;
            wait_nxt  = older;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          wait_nxt  = '0;
        end else if (flag_wen) begin
          wait_nxt = wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) begin
            state_nxt = ST_RESP;
            taken_nxt = eval_taken;
          end
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        wait_nxt  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pending  <= '0;
      wait_cnt <= '0;
      ccc_q    <= 3'b000;
      flags_q  <= 3'b000;
      br_taken <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      wait_cnt <= wait_nxt;
      ccc_q    <= ccc_nxt;
      flags_q  <= flags_nxt;
      br_taken <= taken_nxt;
      if (err_set) pend_err <= 1'b1;
    end
  end

endmodule
